// File: rtl/icmp_tx_if.sv
// +----------------------------------------------------------------------------+
// | Module      : icmp_tx_if                                                   |
// | Description : Request/payload/GMII bundle between the ICMP receive side    |
// |               and the echo-reply transmitter.                              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

interface icmp_tx_if;
    logic        tx_start_en;
    logic [15:0] tx_byte_num;
    logic [47:0] des_mac;
    logic [31:0] des_ip;
    logic [15:0] icmp_id;
    logic [15:0] icmp_seq;
    logic [31:0] reply_checksum;
    logic [7:0]  tx_data;
    logic        tx_req;
    logic        tx_done;
    logic        gmii_tx_en;
    logic [7:0]  gmii_txd;

    // Requesting side: issues the start pulse and serves payload bytes
    modport master (
        output tx_start_en, tx_byte_num, des_mac, des_ip, icmp_id, icmp_seq,
               reply_checksum, tx_data,
        input  tx_req, tx_done, gmii_tx_en, gmii_txd
    );

    // Transmitter side
    modport slave (
        input  tx_start_en, tx_byte_num, des_mac, des_ip, icmp_id, icmp_seq,
               reply_checksum, tx_data,
        output tx_req, tx_done, gmii_tx_en, gmii_txd
    );
endinterface

`default_nettype wire

// File: rtl/icmp_tx.sv
// +----------------------------------------------------------------------------+
// | Module      : icmp_tx                                                      |
// | Description : ICMP echo-reply transmitter. Latches the request fields at   |
// |               a start pulse, computes IP/ICMP checksums, streams preamble, |
// |               Ethernet/IPv4/ICMP headers, payload from a byte FIFO and FCS |
// |               on GMII.                                                     |
// |               Optional macro ICMP_TX_PAD_EN: zero-pad payloads shorter     |
// |               than 18 bytes so the frame reaches the 64-byte minimum.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module icmp_tx #(
    parameter logic [47:0] BOARD_MAC = 48'h00_11_22_33_44_55,
    parameter logic [31:0] BOARD_IP  = {8'd192, 8'd168, 8'd1, 8'd10}
) (
    input wire        clk,
    input wire        rst_n,
    icmp_tx_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_CHECK_SUM = 3'd1,
        S_PREAMBLE  = 3'd2,
        S_ETH_HEAD  = 3'd3,
        S_IP_HEAD   = 3'd4,
        S_ICMP_HEAD = 3'd5,
        S_TX_DATA   = 3'd6,
        S_CRC       = 3'd7
    } state_t;

    // The FSM state always describes the byte currently on the wire; output
    // registers are therefore loaded from the *next* state and counter.
    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_cnt;
    logic [15:0] w_cnt_nxt;

    // Frame parameters captured at start
    logic [15:0] r_len;
    logic [47:0] r_des_mac;
    logic [31:0] r_des_ip;
    logic [15:0] r_id;
    logic [15:0] r_seq;
    logic [31:0] r_rsum;

    logic [15:0] r_ident;
    logic [31:0] r_ip_sum;
    logic [31:0] r_icmp_sum;
    logic [31:0] r_crc;

    logic        r_tx_req;
    logic        r_tx_done;
    logic        r_tx_en;
    logic [7:0]  r_txd;

    logic        w_accept;
    logic        w_frame_end;
    logic [15:0] w_pay_len;
    logic [15:0] w_total_len;
    logic [31:0] w_ip_raw;
    logic [31:0] w_icmp_raw;
    logic [31:0] w_ip_fold;
    logic [31:0] w_icmp_fold;
    logic [7:0]  w_byte;
    logic        w_en;
    logic        w_req;

    logic [13:0][7:0] w_eth;
    logic [19:0][7:0] w_ip_hdr;
    logic [7:0][7:0]  w_icmp_hdr;
    logic [3:0][7:0]  w_fcs;

    // Byte-wise reflected Ethernet CRC-32 update
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            c = (c[0] ^ data[i]) ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        return c;
    endfunction

`ifdef ICMP_TX_PAD_EN
    assign w_pay_len = (r_len < 16'd18) ? 16'd18 : r_len;
`else
    assign w_pay_len = r_len;
`endif

    // A start pulse in the tx_done cycle is dropped even though the FSM is idle
    assign w_accept    = (r_state == S_IDLE) && bus.tx_start_en && !r_tx_done;
    assign w_frame_end = (r_state == S_CRC) && (w_state_nxt == S_IDLE);
    assign w_total_len = r_len + 16'd28;

    assign w_ip_raw = 32'h0000_4500 + {16'h0000, w_total_len} + {16'h0000, r_ident}
                    + 32'h0000_4000 + 32'h0000_4001
                    + {16'h0000, BOARD_IP[31:16]} + {16'h0000, BOARD_IP[15:0]}
                    + {16'h0000, r_des_ip[31:16]} + {16'h0000, r_des_ip[15:0]};
    assign w_icmp_raw  = r_rsum + {16'h0000, r_id} + {16'h0000, r_seq};
    assign w_ip_fold   = {16'h0000, r_ip_sum[31:16]} + {16'h0000, r_ip_sum[15:0]};
    assign w_icmp_fold = {16'h0000, r_icmp_sum[31:16]} + {16'h0000, r_icmp_sum[15:0]};

    // Header images, most significant byte is sent first
    assign w_eth      = {r_des_mac, BOARD_MAC, 16'h0800};
    assign w_ip_hdr   = {16'h4500, w_total_len, r_ident, 16'h4000, 8'h40, 8'h01,
                         r_ip_sum[15:0], BOARD_IP, r_des_ip};
    assign w_icmp_hdr = {16'h0000, r_icmp_sum[15:0], r_id, r_seq};
    assign w_fcs      = ~r_crc;

    // State register and per-state byte counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 16'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state and counter sequencing through the frame sections
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + 16'd1;
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = 16'd0;
                if (w_accept) w_state_nxt = S_CHECK_SUM;
            end
            S_CHECK_SUM: if (r_cnt == 16'd2) begin
                w_state_nxt = S_PREAMBLE;
                w_cnt_nxt   = 16'd0;
            end
            S_PREAMBLE: if (r_cnt == 16'd7) begin
                w_state_nxt = S_ETH_HEAD;
                w_cnt_nxt   = 16'd0;
            end
            S_ETH_HEAD: if (r_cnt == 16'd13) begin
                w_state_nxt = S_IP_HEAD;
                w_cnt_nxt   = 16'd0;
            end
            S_IP_HEAD: if (r_cnt == 16'd19) begin
                w_state_nxt = S_ICMP_HEAD;
                w_cnt_nxt   = 16'd0;
            end
            S_ICMP_HEAD: if (r_cnt == 16'd7) begin
                w_state_nxt = (w_pay_len == 16'd0) ? S_CRC : S_TX_DATA;
                w_cnt_nxt   = 16'd0;
            end
            S_TX_DATA: if (r_cnt == w_pay_len - 16'd1) begin
                w_state_nxt = S_CRC;
                w_cnt_nxt   = 16'd0;
            end
            S_CRC: if (r_cnt == 16'd3) begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = 16'd0;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = 16'd0;
            end
        endcase
    end

    // Byte for the next wire cycle, plus payload request two cycles ahead
    always_comb begin
        w_byte = 8'h00;
        w_en   = 1'b1;
        case (w_state_nxt)
            S_PREAMBLE:  w_byte = (w_cnt_nxt == 16'd7) ? 8'hD5 : 8'h55;
            S_ETH_HEAD:  w_byte = w_eth[4'd13 - w_cnt_nxt[3:0]];
            S_IP_HEAD:   w_byte = w_ip_hdr[5'd19 - w_cnt_nxt[4:0]];
            S_ICMP_HEAD: w_byte = w_icmp_hdr[3'd7 - w_cnt_nxt[2:0]];
            S_TX_DATA:   w_byte = (w_cnt_nxt < r_len) ? bus.tx_data : 8'h00;
            S_CRC:       w_byte = w_fcs[w_cnt_nxt[1:0]];
            default:     w_en   = 1'b0;
        endcase
        w_req = ((w_state_nxt == S_ICMP_HEAD) && (w_cnt_nxt >= 16'd6)
                    && ((w_cnt_nxt - 16'd6) < r_len))
             || ((w_state_nxt == S_TX_DATA) && ((w_cnt_nxt + 16'd2) < r_len));
    end

    // Capture request fields, fold checksums, run CRC, track identification
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_len      <= 16'd0;
            r_des_mac  <= 48'd0;
            r_des_ip   <= 32'd0;
            r_id       <= 16'd0;
            r_seq      <= 16'd0;
            r_rsum     <= 32'd0;
            r_ident    <= 16'd0;
            r_ip_sum   <= 32'd0;
            r_icmp_sum <= 32'd0;
            r_crc      <= 32'hFFFF_FFFF;
        end else begin
            if (w_accept) begin
                r_len     <= bus.tx_byte_num;
                r_des_mac <= bus.des_mac;
                r_des_ip  <= bus.des_ip;
                r_id      <= bus.icmp_id;
                r_seq     <= bus.icmp_seq;
                r_rsum    <= bus.reply_checksum;
            end
            if (r_state == S_CHECK_SUM) begin
                case (r_cnt)
                    16'd0: begin
                        r_ip_sum   <= w_ip_raw;
                        r_icmp_sum <= w_icmp_raw;
                    end
                    16'd1: begin
                        r_ip_sum   <= w_ip_fold;
                        r_icmp_sum <= w_icmp_fold;
                    end
                    default: begin
                        r_ip_sum   <= {16'h0000, ~w_ip_fold[15:0]};
                        r_icmp_sum <= {16'h0000, ~w_icmp_fold[15:0]};
                    end
                endcase
            end
            // CRC covers destination MAC through the last pad byte
            if (w_state_nxt inside {S_ETH_HEAD, S_IP_HEAD, S_ICMP_HEAD, S_TX_DATA}) begin
                r_crc <= crc32_byte(r_crc, w_byte);
            end else if (w_state_nxt != S_CRC) begin
                r_crc <= 32'hFFFF_FFFF;
            end
            if (w_frame_end) r_ident <= r_ident + 16'd1;
        end
    end

    // Registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_req  <= 1'b0;
            r_tx_done <= 1'b0;
            r_tx_en   <= 1'b0;
            r_txd     <= 8'h00;
        end else begin
            r_tx_req  <= w_req;
            r_tx_done <= w_frame_end;
            r_tx_en   <= w_en;
            r_txd     <= w_byte;
        end
    end

    assign bus.tx_req     = r_tx_req;
    assign bus.tx_done    = r_tx_done;
    assign bus.gmii_tx_en = r_tx_en;
    assign bus.gmii_txd   = r_txd;

endmodule

`default_nettype wire

// File: tb/tb_icmp_tx.sv
// +----------------------------------------------------------------------------+
// | Module      : tb_icmp_tx                                                   |
// | Description : Randomized self-checking bench for icmp_tx against a frame   |
// |               model built from the protocol rules.                         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_icmp_tx;
    localparam logic [47:0] C_BOARD_MAC = 48'h00_11_22_33_44_55;
    localparam logic [31:0] C_BOARD_IP  = 32'hC0A8_010A;
`ifdef ICMP_TX_PAD_EN
    localparam int C_PAD_MIN = 18;
`else
    localparam int C_PAD_MIN = 0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    icmp_tx_if bus ();

    icmp_tx #(.BOARD_MAC(C_BOARD_MAC), .BOARD_IP(C_BOARD_IP)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #4 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0]  pay[$];
    logic [7:0]  cap[$];
    logic [7:0]  exp_q[$];
    int          pay_idx   = 0;
    int          en_cnt    = 0;
    int          req_cnt   = 0;
    int          done_cnt  = 0;
    int          first_en  = 0;
    int          last_en   = 0;
    int          done_cyc  = 0;
    int          start_cyc = 0;
    logic [15:0] exp_ident = 16'd0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Payload FIFO: a request seen in cycle c yields the byte during cycle c+1
    initial begin
        logic r;
        bus.tx_data = 8'h00;
        forever begin
            @(negedge clk);
            r = bus.tx_req;
            @(posedge clk);
            #1;
            if (r) begin
                bus.tx_data = (pay_idx < pay.size()) ? pay[pay_idx] : 8'hEE;
                pay_idx++;
            end else begin
                bus.tx_data = 8'($urandom);
            end
        end
    end

    // Wire monitor
    initial begin
        forever begin
            @(negedge clk);
            if (bus.gmii_tx_en) begin
                cap.push_back(bus.gmii_txd);
                if (en_cnt == 0) first_en = cyc;
                last_en = cyc;
                en_cnt++;
            end
            if (bus.tx_req) req_cnt++;
            if (bus.tx_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    function automatic logic [15:0] ones_sum_inv(input logic [31:0] s);
        logic [31:0] t;
        t = s;
        while (t > 32'hFFFF) t = (t & 32'hFFFF) + (t >> 16);
        return ~t[15:0];
    endfunction

    function automatic void push16(input logic [15:0] v);
        exp_q.push_back(v[15:8]);
        exp_q.push_back(v[7:0]);
    endfunction

    function automatic void push32(input logic [31:0] v);
        push16(v[31:16]);
        push16(v[15:0]);
    endfunction

    function automatic logic [31:0] ref_crc(input int from);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        for (int i = from; i < exp_q.size(); i++) begin
            c = c ^ {24'h0, exp_q[i]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        return c;
    endfunction

    function automatic void build_expected(input int n, input logic [47:0] dm,
                                           input logic [31:0] dip, input logic [15:0] id,
                                           input logic [15:0] seq, input logic [31:0] rsum,
                                           input logic [15:0] ident);
        int          p;
        logic [31:0] s;
        logic [47:0] bm;
        logic [31:0] bip;
        logic [31:0] crc;
        p   = (n < C_PAD_MIN) ? C_PAD_MIN : n;
        bm  = C_BOARD_MAC;
        bip = C_BOARD_IP;
        exp_q.delete();
        repeat (7) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        push16(dm[47:32]); push32(dm[31:0]);
        push16(bm[47:32]); push32(bm[31:0]);
        push16(16'h0800);
        s = 32'h4500 + 32'(28 + n) + 32'(ident) + 32'h4000 + 32'h4001
          + 32'(bip[31:16]) + 32'(bip[15:0]) + 32'(dip[31:16]) + 32'(dip[15:0]);
        push16(16'h4500); push16(16'(28 + n)); push16(ident); push16(16'h4000);
        push16(16'h4001); push16(ones_sum_inv(s)); push32(bip); push32(dip);
        push16(16'h0000);
        push16(ones_sum_inv(rsum + 32'(id) + 32'(seq)));
        push16(id); push16(seq);
        for (int i = 0; i < n; i++) exp_q.push_back(pay[i]);
        for (int i = n; i < p; i++) exp_q.push_back(8'h00);
        crc = ~ref_crc(8);
        exp_q.push_back(crc[7:0]);
        exp_q.push_back(crc[15:8]);
        exp_q.push_back(crc[23:16]);
        exp_q.push_back(crc[31:24]);
    endfunction

    function automatic logic [15:0] cap16(input int idx);
        if (idx + 1 < cap.size()) return {cap[idx], cap[idx + 1]};
        return 16'hDEAD;
    endfunction

    task automatic drive_start(input int n, input logic [47:0] dm, input logic [31:0] dip,
                               input logic [15:0] id, input logic [15:0] seq,
                               input logic [31:0] rsum);
        @(posedge clk);
        #1;
        bus.tx_byte_num    = 16'(n);
        bus.des_mac        = dm;
        bus.des_ip         = dip;
        bus.icmp_id        = id;
        bus.icmp_seq       = seq;
        bus.reply_checksum = rsum;
        bus.tx_start_en    = 1'b1;
        start_cyc          = cyc;
        @(posedge clk);
        #1;
        bus.tx_start_en    = 1'b0;
        // Scramble request fields: the frame in flight must not follow them
        bus.tx_byte_num    = 16'($urandom_range(0, 1472));
        bus.des_mac        = {16'($urandom), 32'($urandom)};
        bus.des_ip         = 32'($urandom);
        bus.icmp_id        = 16'($urandom);
        bus.icmp_seq       = 16'($urandom);
        bus.reply_checksum = 32'($urandom);
    endtask

    task automatic send(input int n, input logic [47:0] dm, input logic [31:0] dip,
                        input logic [15:0] id, input logic [15:0] seq,
                        input logic [31:0] rsum_in, input bit use_rsum, input bit inject_done);
        logic [31:0] rsum;
        bit          done_ok;
        int          p;
        p = (n < C_PAD_MIN) ? C_PAD_MIN : n;
        pay.delete();
        for (int i = 0; i < n; i++) pay.push_back(8'($urandom));
        rsum = 32'd0;
        for (int i = 0; i < n; i += 2) rsum += 32'({pay[i], (i + 1 < n) ? pay[i + 1] : 8'h00});
        if (use_rsum) rsum = rsum_in;
        build_expected(n, dm, dip, id, seq, rsum, exp_ident);
        pay_idx  = 0;
        cap.delete();
        en_cnt   = 0;
        req_cnt  = 0;
        done_cnt = 0;
        drive_start(n, dm, dip, id, seq, rsum);
        done_ok = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            #1;
            if (i == 20) bus.tx_start_en = 1'b1;
            if (i == 21) bus.tx_start_en = 1'b0;
            if (done_cnt > 0) begin
                done_ok = 1'b1;
                break;
            end
        end
        bus.tx_start_en = 1'b0;
        if (inject_done && done_ok) begin
            bus.tx_start_en = 1'b1;
            @(posedge clk);
            #1;
            bus.tx_start_en = 1'b0;
        end
        repeat (8) @(negedge clk);
        #1;
        chk("done_seen", 64'(done_ok), 64'd1);
        chk("latency", 64'(first_en - start_cyc), 64'd4);
        chk("en_cycles", 64'(en_cnt), 64'(54 + p));
        chk("req_count", 64'(req_cnt), 64'(n));
        chk("done_count", 64'(done_cnt), 64'd1);
        chk("done_after_fcs", 64'(done_cyc), 64'(last_en + 1));
        chk("frame_len", 64'(cap.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            chk($sformatf("frame_byte_%0d", i),
                (i < cap.size()) ? 64'(cap[i]) : 64'hDEAD, 64'(exp_q[i]));
        end
        if (done_ok) exp_ident = exp_ident + 16'd1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] ident1;
        logic [15:0] cs1;
        logic [47:0] dm;
        int          nr;
        int          n_list[5];
        bus.tx_start_en    = 1'b0;
        bus.tx_byte_num    = 16'd0;
        bus.des_mac        = 48'd0;
        bus.des_ip         = 32'd0;
        bus.icmp_id        = 16'd0;
        bus.icmp_seq       = 16'd0;
        bus.reply_checksum = 32'd0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx_req", 64'(bus.tx_req), 64'd0);
        chk("rst_tx_done", 64'(bus.tx_done), 64'd0);
        chk("rst_tx_en", 64'(bus.gmii_tx_en), 64'd0);
        chk("rst_txd", 64'(bus.gmii_txd), 64'd0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("idle_tx_en", 64'(bus.gmii_tx_en), 64'd0);

        // Reference checksum frame
        dm = {16'($urandom), 32'($urandom)};
        send(32, dm, 32'hC0A8_0166, 16'h0001, 16'h0005, 32'h0001_2345, 1'b1, 1'b0);
        chk("total_length", 64'(cap16(24)), 64'h003C);
        chk("ip_checksum", 64'(cap16(32)), 64'hB700);
        chk("icmp_checksum", 64'(cap16(44)), 64'hDCB3);
        chk("en_cycles_n32", 64'(en_cnt), 64'd86);
        chk("req_n32", 64'(req_cnt), 64'd32);

        // Random payload frame
        send(100, {16'($urandom), 32'($urandom)}, 32'($urandom), 16'($urandom),
             16'($urandom), 32'd0, 1'b0, 1'b0);

        // Empty payload
        send(0, {16'($urandom), 32'($urandom)}, 32'($urandom), 16'($urandom),
             16'($urandom), 32'd0, 1'b0, 1'b0);
        chk("en_cycles_n0", 64'(en_cnt), 64'((C_PAD_MIN == 18) ? 72 : 54));
        chk("req_n0", 64'(req_cnt), 64'd0);

        // Odd length back-to-back, second with a start during tx_done
        send(33, dm, 32'hC0A8_0166, 16'h1234, 16'h0001, 32'd0, 1'b0, 1'b0);
        ident1 = cap16(26);
        cs1    = cap16(32);
        send(33, dm, 32'hC0A8_0166, 16'h1234, 16'h0002, 32'd0, 1'b0, 1'b1);
        chk("ident_step", 64'(cap16(26)), 64'(ident1 + 16'd1));
        chk("ip_csum_step", 64'(cs1 - cap16(32)), 64'd1);

        // Reset in the middle of the IP header
        pay.delete();
        for (int i = 0; i < 40; i++) pay.push_back(8'($urandom));
        pay_idx = 0;
        drive_start(40, dm, 32'($urandom), 16'h0001, 16'h0001, 32'd0);
        repeat (29) @(posedge clk);
        #2;
        chk("en_before_reset", 64'(bus.gmii_tx_en), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("en_async_reset", 64'(bus.gmii_tx_en), 64'd0);
        chk("txd_async_reset", 64'(bus.gmii_txd), 64'd0);
        chk("req_async_reset", 64'(bus.tx_req), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n     = 1'b1;
        exp_ident = 16'd0;
        send(45, {16'($urandom), 32'($urandom)}, 32'($urandom), 16'($urandom),
             16'($urandom), 32'd0, 1'b0, 1'b0);
        chk("ident_after_reset", 64'(cap16(26)), 64'd0);

        // Length boundaries and random lengths
        n_list = '{1, 17, 18, 19, 1472};
        for (int k = 0; k < 5; k++) begin
            send(n_list[k], {16'($urandom), 32'($urandom)}, 32'($urandom), 16'($urandom),
                 16'($urandom), 32'd0, 1'b0, 1'b0);
        end
        for (int k = 0; k < 3; k++) begin
            nr = int'($urandom_range(0, 80));
            send(nr, {16'($urandom), 32'($urandom)}, 32'($urandom), 16'($urandom),
                 16'($urandom), 32'd0, 1'b0, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

`default_nettype wire
